alu_flag_stage: RTL and testbench
=================================

// Module: alu_flag_stage
// PURPOSE
//  EX->MEM stage directly downstream of the 32-bit ALU adder. Registers sum/carryout/overflow with rd
//  and PC behind a 2-entry valid/ready skid buffer. Traps signed overflow (MIPS ADD/ADDI/SUB): kills
//  writeback, latches EPC, stalls until acked. Saturating overflow counter for debug/perf.
// PARAMETERS
//  N      32  datapath width of sum
//  CNT_W  16  width of ovf_count
// PORTS
//  clk        in   1      clock; all state on rising edge
//  rst_n      in   1      async active-low reset
//  in_valid   in   1      upstream ALU result valid
//  in_ready   out  1      stage can accept (registered)
//  in_sum     in   N      adder sum
//  in_carry   in   1      adder carryout
//  in_ovf     in   1      adder signed overflow
//  in_trap_en in   1      1 = signed op, overflow traps; 0 = unsigned (ADDU), never traps
//  in_rd      in   5      destination register
//  in_pc      in   32     PC of instruction
//  out_valid  out  1      head entry valid
//  out_ready  in   1      downstream accepts
//  out_sum    out  N      head sum
//  out_carry  out  1      head carryout
//  out_ovf    out  1      head overflow
//  out_rd     out  5      head rd
//  out_wen    out  1      head writeback enable (0 if trapped or rd==0)
//  flush      in   1      drop all buffered entries
//  exc_pending out 1      overflow exception raised, awaiting ack
//  exc_epc    out  32     PC of trapping instruction
//  exc_ack    in   1      clears exc_pending
//  ovf_count  out  CNT_W  accepted entries with in_ovf=1, saturating
// BEHAVIOUR
//  - Reset (rst_n=0, async): both entries invalid; out_valid=0, in_ready=1, exc_pending=0,
//    exc_epc=0, ovf_count=0, out_* data=0.
//  - Accept = in_valid & in_ready; pop = out_valid & out_ready. Entry count 0..2.
//  - in_ready = (count<2) & ~exc_pending, registered (depends only on state, not on out_ready).
//  - Latency: accepted at edge k -> out_valid at k+1 if buffer empty. FIFO order preserved.
//  - Simultaneous accept+pop with count==2 impossible (in_ready=0); with count 1: count stays 1.
//  - Data stable while out_valid & ~out_ready.
//  - out_wen = ~trap & (rd!=0), computed at accept, stored per entry.
//  - Trap: accept with in_trap_en & in_ovf -> entry stored with wen=0; exc_pending<=1,
//    exc_epc<=in_pc same edge. Entry still drains downstream (wen=0).
//  - exc_ack while exc_pending: exc_pending<=0 next edge; in_ready may rise same edge. Ack while
//    not pending ignored. No new trap while pending (in_ready=0 guarantees).
//  - flush: priority over accept and pop; entries invalid next edge, out_valid=0; exc_pending,
//    exc_epc, ovf_count unchanged. Accept in flush cycle discarded (not counted).
//  - ovf_count += 1 per accepted in_ovf=1 (trap_en irrelevant); holds at 2^CNT_W-1.
//  - Reset mid-operation: all state cleared immediately, regardless of handshake.
// STRUCTURE
//  - Package alu_stage_pkg: typedef struct packed {sum, carry, ovf, rd, wen} alu_entry_t;
//    localparam REG_ZERO = 5'd0.
//  - One sub-module: alu_skid_buf (2-entry, parameterized on alu_entry_t); trap/EPC/counter logic
//    in alu_flag_stage top.
// TESTING
//  1. Reset then in_sum=0x7FFFFFFF, carry=0, ovf=0, rd=8, out_ready=1 -> out_valid next cycle,
//     out_sum=0x7FFFFFFF, out_wen=1.
//  2. out_ready=0, push 3 entries back-to-back -> in_ready=0 after 2nd; release -> order 1,2,3 intact.
//  3. in_sum=0x80000000, ovf=1, trap_en=1, pc=0x00400020 -> out_wen=0, exc_pending=1,
//     exc_epc=0x00400020, in_ready=0 until exc_ack; ovf_count=1.
//  4. Same overflow with trap_en=0 (ADDU) -> out_wen=1, exc_pending=0, ovf_count increments.
//  5. 2 entries held, assert flush with in_valid=1 -> out_valid=0 next cycle, count 0, ovf_count unchanged.
//  6. rd=0 non-trapping -> out_wen=0; preload ovf_count to 0xFFFF via 65535 overflows -> stays 0xFFFF;
//     rst_n low mid-stall -> all outputs to reset values asynchronously.

Source files
------------

// File: rtl/alu_stage_pkg.sv
// alu_stage_pkg: shared entry type and constants for the ALU flag stage.
//   alu_entry_t - one buffered ALU result (sum, carry, ovf, rd, writeback enable)
//   REG_ZERO    - architectural zero register; writes to it are suppressed
//   entry_wen   - writeback enable for an accepted result
package alu_stage_pkg;
  localparam int SUM_W = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;
  typedef struct packed {
    logic [SUM_W-1:0] sum;
    logic             carry;
    logic             ovf;
    logic [4:0]       rd;
    logic             wen;
  } alu_entry_t;
  function automatic logic entry_wen(input logic trap, input logic [4:0] rd);
    return ~trap & (rd != REG_ZERO);
  endfunction
endpackage

// File: rtl/alu_skid_buf.sv
// alu_skid_buf: 2-entry in-order buffer, head entry presented on the output.
//   push_i/pop_i/flush_i - write, head-consume and drop-all controls (flush wins)
//   data_i/data_o        - entry in / head entry out; valid_o marks the head valid
//   count_d_o            - occupancy after this edge, used by the parent for a registered ready
module alu_skid_buf import alu_stage_pkg::*; #(
  parameter type T = alu_entry_t
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic       flush_i,
  input  T           data_i,
  output T           data_o,
  output logic       valid_o,
  output logic [1:0] count_d_o
);
  T     e0_q, e0_d, e1_q, e1_d, s0;
  logic v0_q, v0_d, v1_q, v1_d, sv0, sv1;
  // Pop shifts entry 1 into the head first; the push then lands in the first free slot.
  always_comb begin
    s0        = pop_i ? e1_q : e0_q;
    sv0       = pop_i ? v1_q : v0_q;
    sv1       = pop_i ? 1'b0 : v1_q;
    e0_d      = (push_i & ~sv0) ? data_i : s0;
    e1_d      = (push_i & sv0) ? data_i : e1_q;
    v0_d      = ~flush_i & (sv0 | push_i);
    v1_d      = ~flush_i & (sv1 | (push_i & sv0));
    count_d_o = {1'b0, v0_d} + {1'b0, v1_d};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q <= '0;
      e1_q <= '0;
      v0_q <= 1'b0;
      v1_q <= 1'b0;
    end else begin
      e0_q <= e0_d;
      e1_q <= e1_d;
      v0_q <= v0_d;
      v1_q <= v1_d;
    end
  end
  assign data_o  = e0_q;
  assign valid_o = v0_q;
endmodule

// File: rtl/alu_flag_stage.sv
// alu_flag_stage: EX->MEM register stage after the ALU adder with overflow trap and counter.
//   in_*        - upstream result + valid/ready (in_ready registered)
//   out_*       - head entry + valid/ready; out_wen is 0 for trapped results or rd==0
//   flush       - drops buffered entries; trap/EPC/counter state kept
//   exc_*       - pending overflow exception, its EPC, and the clearing ack
//   ovf_count   - saturating count of accepted results with in_ovf set
// N must equal alu_stage_pkg::SUM_W.
module alu_flag_stage import alu_stage_pkg::*; #(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_sum,
  input  logic             in_carry,
  input  logic             in_ovf,
  input  logic             in_trap_en,
  input  logic [4:0]       in_rd,
  input  logic [31:0]      in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_sum,
  output logic             out_carry,
  output logic             out_ovf,
  output logic [4:0]       out_rd,
  output logic             out_wen,
  input  logic             flush,
  output logic             exc_pending,
  output logic [31:0]      exc_epc,
  input  logic             exc_ack,
  output logic [CNT_W-1:0] ovf_count
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  alu_entry_t       entry, head;
  logic             push, pop, trap, in_ready_q, in_ready_d, exc_q, exc_d;
  logic [31:0]      epc_q, epc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       count_next;
  // An accept in a flush cycle is discarded entirely: not stored, not counted, no trap.
  always_comb begin
    push       = in_valid & in_ready_q & ~flush;
    pop        = out_valid & out_ready;
    trap       = push & in_trap_en & in_ovf;
    entry      = '{sum: in_sum, carry: in_carry, ovf: in_ovf, rd: in_rd,
                   wen: entry_wen(in_trap_en & in_ovf, in_rd)};
    exc_d      = trap | (exc_q & ~exc_ack);
    epc_d      = trap ? in_pc : epc_q;
    cnt_d      = (push & in_ovf & (cnt_q != CNT_MAX)) ? cnt_q + CNT_W'(1) : cnt_q;
    in_ready_d = (count_next < 2'd2) & ~exc_d;
  end
  alu_skid_buf #(.T(alu_entry_t)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push),
    .pop_i     (pop),
    .flush_i   (flush),
    .data_i    (entry),
    .data_o    (head),
    .valid_o   (out_valid),
    .count_d_o (count_next)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q <= 1'b1;
      exc_q      <= 1'b0;
      epc_q      <= '0;
      cnt_q      <= '0;
    end else begin
      in_ready_q <= in_ready_d;
      exc_q      <= exc_d;
      epc_q      <= epc_d;
      cnt_q      <= cnt_d;
    end
  end
  assign in_ready    = in_ready_q;
  assign out_sum     = head.sum;
  assign out_carry   = head.carry;
  assign out_ovf     = head.ovf;
  assign out_rd      = head.rd;
  assign out_wen     = head.wen;
  assign exc_pending = exc_q;
  assign exc_epc     = epc_q;
  assign ovf_count   = cnt_q;
endmodule

// File: tb/tb_alu_flag_stage.sv
// tb_alu_flag_stage: table vectors, directed corner sequences and random traffic vs a queue model.
module tb_alu_flag_stage;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 0, in_carry = 0, in_ovf = 0, in_trap_en = 0, out_ready = 0, flush = 0, exc_ack = 0;
  logic [31:0] in_sum = 0, in_pc = 0, out_sum, exc_epc;
  logic [4:0]  in_rd = 0, out_rd;
  logic        in_ready, out_valid, out_carry, out_ovf, out_wen, exc_pending;
  logic [15:0] ovf_count;
  int          total = 0, passed = 0;
  typedef struct {
    logic [31:0] sum;
    logic        carry, ovf;
    logic [4:0]  rd;
    logic        wen;
  } m_t;
  m_t          mq[$];
  logic        exc_m = 0;
  logic [31:0] epc_m = 0;
  int          cnt_m = 0;
  logic [31:0] seen[$];
  typedef struct {
    logic v; logic [31:0] sum; logic c, o, te; logic [4:0] rd; logic [31:0] pc; logic ack;
    logic e_v; logic [31:0] e_sum; logic e_c, e_o, e_wen, e_rdy, e_exc; logic [31:0] e_epc; int e_cnt;
  } vec_t;
  vec_t vec[7];
  alu_flag_stage #(.N(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
    .in_carry(in_carry), .in_ovf(in_ovf), .in_trap_en(in_trap_en), .in_rd(in_rd), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_carry(out_carry),
    .out_ovf(out_ovf), .out_rd(out_rd), .out_wen(out_wen), .flush(flush),
    .exc_pending(exc_pending), .exc_epc(exc_epc), .exc_ack(exc_ack), .ovf_count(ovf_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask
  task automatic model_reset();
    mq.delete();
    exc_m = 0;
    epc_m = 0;
    cnt_m = 0;
  endtask
  task automatic mcheck();
    chk("m_out_valid", 32'(out_valid), 32'(mq.size() > 0));
    chk("m_in_ready", 32'(in_ready), 32'(mq.size() < 2 && !exc_m));
    chk("m_exc_pending", 32'(exc_pending), 32'(exc_m));
    chk("m_exc_epc", exc_epc, epc_m);
    chk("m_ovf_count", 32'(ovf_count), 32'(cnt_m));
    if (mq.size() > 0) begin
      chk("m_out_sum", out_sum, mq[0].sum);
      chk("m_out_carry", 32'(out_carry), 32'(mq[0].carry));
      chk("m_out_ovf", 32'(out_ovf), 32'(mq[0].ovf));
      chk("m_out_rd", 32'(out_rd), 32'(mq[0].rd));
      chk("m_out_wen", 32'(out_wen), 32'(mq[0].wen));
    end
  endtask
  // One clock: the model applies the handshake rules to the inputs seen at the edge.
  task automatic step();
    logic acc, pop;
    m_t   e;
    if (out_valid && out_ready) seen.push_back(out_sum);
    @(posedge clk);
    acc = in_valid && mq.size() < 2 && !exc_m;
    pop = mq.size() > 0 && out_ready;
    if (exc_ack) exc_m = 0;
    if (flush) mq.delete();
    else begin
      if (pop) mq.delete(0);
      if (acc) begin
        e.sum = in_sum; e.carry = in_carry; e.ovf = in_ovf; e.rd = in_rd;
        e.wen = !(in_trap_en && in_ovf) && in_rd != 0;
        mq.push_back(e);
        if (in_ovf && cnt_m < 65535) cnt_m++;
        if (in_trap_en && in_ovf) begin
          exc_m = 1;
          epc_m = in_pc;
        end
      end
    end
    #1;
    mcheck();
  endtask
  function automatic vec_t mk(logic v, logic [31:0] sum, logic c, logic o, logic te, logic [4:0] rd,
                              logic [31:0] pc, logic ack, logic e_v, logic [31:0] e_sum, logic e_c,
                              logic e_o, logic e_wen, logic e_rdy, logic e_exc, logic [31:0] e_epc, int e_cnt);
    vec_t r;
    r.v = v; r.sum = sum; r.c = c; r.o = o; r.te = te; r.rd = rd; r.pc = pc; r.ack = ack;
    r.e_v = e_v; r.e_sum = e_sum; r.e_c = e_c; r.e_o = e_o; r.e_wen = e_wen; r.e_rdy = e_rdy;
    r.e_exc = e_exc; r.e_epc = e_epc; r.e_cnt = e_cnt;
    return r;
  endfunction
  task automatic set_in(logic v, logic [31:0] sum, logic c, logic o, logic te, logic [4:0] rd, logic [31:0] pc);
    in_valid = v; in_sum = sum; in_carry = c; in_ovf = o; in_trap_en = te; in_rd = rd; in_pc = pc;
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_in_ready"}, 32'(in_ready), 1);
    chk({tag, "_exc_pending"}, 32'(exc_pending), 0);
    chk({tag, "_exc_epc"}, exc_epc, 0);
    chk({tag, "_ovf_count"}, 32'(ovf_count), 0);
    chk({tag, "_out_data"}, {out_sum[25:0], out_carry, out_ovf, out_wen, out_rd[2:0]} | 32'(out_rd), 0);
  endtask
  initial begin
    logic [31:0] cnt_snap;
    vec[0] = mk(1, 32'h7FFFFFFF, 0, 0, 1, 8, 32'h00400000, 0,  1, 32'h7FFFFFFF, 0, 0, 1, 1, 0, 32'h0, 0);
    vec[1] = mk(1, 32'h80000000, 0, 1, 1, 9, 32'h00400020, 0,  1, 32'h80000000, 0, 1, 0, 0, 1, 32'h00400020, 1);
    vec[2] = mk(1, 32'h00000001, 0, 0, 1, 3, 32'h00400024, 0,  0, 32'h0, 0, 0, 0, 0, 1, 32'h00400020, 1);
    vec[3] = mk(0, 32'h00000000, 0, 0, 0, 0, 32'h00000000, 1,  0, 32'h0, 0, 0, 0, 1, 0, 32'h00400020, 1);
    vec[4] = mk(1, 32'h80000000, 1, 1, 0, 5, 32'h00400040, 0,  1, 32'h80000000, 1, 1, 1, 1, 0, 32'h00400020, 2);
    vec[5] = mk(1, 32'h00001234, 0, 0, 1, 0, 32'h00400044, 0,  1, 32'h00001234, 0, 0, 0, 1, 0, 32'h00400020, 2);
    vec[6] = mk(0, 32'h00000000, 0, 0, 0, 0, 32'h00000000, 1,  0, 32'h0, 0, 0, 0, 1, 0, 32'h00400020, 2);
    #12;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      set_in(vec[i].v, vec[i].sum, vec[i].c, vec[i].o, vec[i].te, vec[i].rd, vec[i].pc);
      exc_ack = vec[i].ack;
      step();
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vec[i].e_v));
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vec[i].e_rdy));
      chk($sformatf("vec%0d_exc_pending", i), 32'(exc_pending), 32'(vec[i].e_exc));
      chk($sformatf("vec%0d_exc_epc", i), exc_epc, vec[i].e_epc);
      chk($sformatf("vec%0d_ovf_count", i), 32'(ovf_count), 32'(vec[i].e_cnt));
      if (vec[i].e_v) begin
        chk($sformatf("vec%0d_out_sum", i), out_sum, vec[i].e_sum);
        chk($sformatf("vec%0d_out_carry", i), 32'(out_carry), 32'(vec[i].e_c));
        chk($sformatf("vec%0d_out_ovf", i), 32'(out_ovf), 32'(vec[i].e_o));
        chk($sformatf("vec%0d_out_wen", i), 32'(out_wen), 32'(vec[i].e_wen));
      end
    end
    exc_ack = 0;
    // Back-pressure: three pushes against a stalled output, then drain in order.
    seen.delete();
    out_ready = 0;
    set_in(1, 32'h11111111, 0, 0, 1, 1, 32'h100); step();
    chk("bp_ready_after1", 32'(in_ready), 1);
    set_in(1, 32'h22222222, 0, 0, 1, 2, 32'h104); step();
    chk("bp_ready_after2", 32'(in_ready), 0);
    set_in(1, 32'h33333333, 0, 0, 1, 3, 32'h108); step();
    chk("bp_head_stable", out_sum, 32'h11111111);
    out_ready = 1;
    step();
    step();
    in_valid = 0;
    step();
    step();
    chk("bp_drain_count", seen.size(), 3);
    if (seen.size() == 3) begin
      chk("bp_order0", seen[0], 32'h11111111);
      chk("bp_order1", seen[1], 32'h22222222);
      chk("bp_order2", seen[2], 32'h33333333);
    end
    // Flush with two held entries, then flush on a cycle whose accept must be discarded.
    out_ready = 0;
    set_in(1, 32'hA0000001, 0, 1, 0, 4, 32'h200); step();
    set_in(1, 32'hA0000002, 0, 1, 0, 4, 32'h204); step();
    cnt_snap = 32'(cnt_m);
    flush = 1; set_in(1, 32'hA0000003, 0, 1, 0, 4, 32'h208); step();
    flush = 0;
    chk("flush2_out_valid", 32'(out_valid), 0);
    chk("flush2_ovf_count", 32'(ovf_count), cnt_snap);
    set_in(1, 32'hA0000004, 0, 0, 0, 4, 32'h20C); step();
    cnt_snap = 32'(cnt_m);
    flush = 1; set_in(1, 32'hA0000005, 0, 1, 1, 4, 32'h210); step();
    flush = 0; in_valid = 0;
    chk("flush1_out_valid", 32'(out_valid), 0);
    chk("flush1_ovf_count", 32'(ovf_count), cnt_snap);
    chk("flush1_no_trap", 32'(exc_pending), 0);
    step();
    chk("flush1_stays_empty", 32'(out_valid), 0);
    // Saturate the overflow counter with unsigned overflows.
    out_ready = 1;
    set_in(1, 32'h80000000, 1, 1, 0, 7, 32'h300);
    for (int i = 0; i < 65540; i++) step();
    chk("sat_ovf_count", 32'(ovf_count), 32'h0000FFFF);
    // Asynchronous reset in the middle of an exception stall.
    out_ready = 0;
    set_in(1, 32'h80000000, 0, 1, 1, 6, 32'h00400080); step();
    in_valid = 0;
    chk("stall_exc_pending", 32'(exc_pending), 1);
    #2 rst_n = 0;
    #1;
    chk_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1;
    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(3) != 0, $urandom, $urandom_range(1) != 0, $urandom_range(3) == 0,
             $urandom_range(1) != 0, 5'($urandom_range(7)), $urandom);
      out_ready = $urandom_range(2) != 0;
      exc_ack   = $urandom_range(3) == 0;
      flush     = $urandom_range(31) == 0;
      step();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
